// File: rtl/hub75_rx.sv
// HUB75 receiver: rebuilds full-colour pixels from the bit-plane stream and emits them as valid/ready writes.
// Define HUB75_RX_SYNC_EN to put a 2-flop synchronizer on every HUB75 input.
module hub75_rx #(
  parameter int hpixel_p     = 64,
  parameter int vpixel_p     = 32,
  parameter int bpp_p        = 8,
  parameter int addr_width_p = $clog2(hpixel_p*vpixel_p)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_h75_clk,
  input  logic                          i_stb,
  input  logic                          i_a,
  input  logic                          i_b,
  input  logic                          i_c,
  input  logic                          i_d,
  input  logic                          i_r1,
  input  logic                          i_g1,
  input  logic                          i_b1,
  input  logic                          i_r2,
  input  logic                          i_g2,
  input  logic                          i_b2,
  output logic                          o_wr_valid,
  input  logic                          i_wr_ready,
  output logic [addr_width_p-1:0]       o_wr_addr,
  output logic [2:0][bpp_p-1:0]         o_wr_data,
  output logic                          o_frame_done,
  output logic                          o_seq_err,
  output logic                          o_overrun
);
  localparam int cnt_w = $clog2(hpixel_p + 2);
  localparam int idx_w = $clog2(2 * hpixel_p);
  localparam int x_w   = $clog2(hpixel_p);
  localparam int pl_w  = (bpp_p > 1) ? $clog2(bpp_p) : 1;

  typedef enum logic {COLLECT, FLUSH} state_t;
  state_t state_q, state_d;

  logic [11:0] raw, samp, q;
  logic        clk_d, stb_d;
  assign raw = {i_h75_clk, i_stb, i_d, i_c, i_b, i_a, i_r1, i_g1, i_b1, i_r2, i_g2, i_b2};

`ifdef HUB75_RX_SYNC_EN
  logic [11:0] sync1, sync2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end
  assign samp = sync2;
`else
  assign samp = raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      clk_d <= 1'b0;
      stb_d <= 1'b0;
    end else begin
      q     <= samp;
      clk_d <= q[11];
      stb_d <= q[10];
    end
  end

  logic       clk_rise, stb_rise;
  logic [3:0] row;
  logic [5:0] pix;
  assign clk_rise = q[11] & ~clk_d;
  assign stb_rise = q[10] & ~stb_d;
  assign row      = q[9:6];
  assign pix      = q[5:0];

  logic [hpixel_p-1:0][5:0]            shbuf, shbuf_n;
  logic [hpixel_p-1:0][5:0][bpp_p-1:0] acc;
  logic [cnt_w-1:0] cnt, cnt_n;
  logic [pl_w-1:0]  plane, eff_plane;
  logic [3:0]       cur_row;
  logic [idx_w-1:0] idx;
  logic cnt_bad, row_bad, accept, final_pl, xfer, last;
  logic seq_err_d, overrun_d, done_d;

  // A shift seen in the same cycle as the latch is folded in before the copy.
  always_comb begin
    shbuf_n = clk_rise ? {shbuf[hpixel_p-2:0], pix} : shbuf;
    cnt_n   = cnt;
    if (clk_rise && cnt != cnt_w'(hpixel_p + 1)) cnt_n = cnt + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_bad   = cnt_n != cnt_w'(hpixel_p);
    row_bad   = !cnt_bad && (row != cur_row) && (plane != '0);
    accept    = stb_rise && !cnt_bad;
    eff_plane = row_bad ? '0 : plane;
    final_pl  = accept && (eff_plane == pl_w'(bpp_p - 1));
    xfer      = (state_q == FLUSH) && i_wr_ready;
    last      = idx == idx_w'(2 * hpixel_p - 1);
    seq_err_d = stb_rise && (cnt_bad || row_bad);
    overrun_d = stb_rise && (state_q == FLUSH);
    done_d    = 1'b0;
    case (state_q)
      COLLECT: if (final_pl) state_d = FLUSH;
      FLUSH: begin
        if (stb_rise) state_d = final_pl ? FLUSH : COLLECT;
        else if (xfer && last) begin
          state_d = COLLECT;
          done_d  = cur_row == 4'(vpixel_p / 2 - 1);
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= COLLECT;
      cnt          <= '0;
      plane        <= '0;
      cur_row      <= '0;
      idx          <= '0;
      o_seq_err    <= 1'b0;
      o_overrun    <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt          <= accept ? '0 : cnt_n;
      if (accept) begin
        cur_row <= row;
        plane   <= final_pl ? '0 : eff_plane + 1'b1;
      end
      if (final_pl)  idx <= '0;
      else if (xfer) idx <= idx + 1'b1;
      o_seq_err    <= seq_err_d;
      o_overrun    <= overrun_d;
      o_frame_done <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shbuf <= shbuf_n;
    if (accept)
      for (int unsigned xx = 0; xx < hpixel_p; xx++)
        for (int unsigned cc = 0; cc < 6; cc++)
          acc[xx[x_w-1:0]][cc[2:0]][eff_plane] <= shbuf_n[xx[x_w-1:0]][cc[2:0]];
  end

  logic                    half;
  logic [idx_w-1:0]        xi;
  logic [x_w-1:0]          x;
  logic [addr_width_p-1:0] y_a;
  assign o_wr_valid = state_q == FLUSH;

  // Addr/data are forced to zero outside FLUSH so reset leaves every output at 0.
  always_comb begin
    half      = idx >= idx_w'(hpixel_p);
    xi        = half ? idx - idx_w'(hpixel_p) : idx;
    x         = xi[x_w-1:0];
    y_a       = addr_width_p'(cur_row) + (half ? addr_width_p'(vpixel_p / 2) : '0);
    o_wr_addr = '0;
    o_wr_data = '0;
    if (o_wr_valid) begin
      o_wr_addr = y_a * addr_width_p'(hpixel_p) + addr_width_p'(x);
      o_wr_data = half ? acc[x][2:0] : acc[x][5:3];
    end
  end
endmodule

// File: doc/hub75_rx.md
# hub75_rx

HUB75 panel-side receiver: samples the HUB75 lines (CLK, STB, A–D, R1/G1/B1, R2/G2/B2) with the system clock and rebuilds full-colour pixels from the bit-plane stream. Emits pixel writes over a valid/ready port into a capture framebuffer. Serves as the loopback checker and capture path for `hub75_framebuf` and as the front end of a panel emulator. Geometry is 1/16 scan: 16 row addresses, two half-panels.

## Interface
- `hpixel_p`, 64, pixels per row (shift length per latch)
- `vpixel_p`, 32, panel height; must equal 32 (16 row addresses × 2 halves)
- `bpp_p`, 8, bits per colour channel (bit planes per row)
- `addr_width_p`, derived = $clog2(hpixel_p*vpixel_p), write address width

- `clk` in 1, system clock; must be ≥4× HUB75 CLK frequency
- `rst` in 1, asynchronous, active-high reset
- `i_h75_clk` in 1, HUB75 shift clock; data shifted on rising edge
- `i_stb` in 1, HUB75 latch; row/plane committed on rising edge
- `i_a`,`i_b`,`i_c`,`i_d` in 1 each, row address, `i_a` = LSB
- `i_r1`,`i_g1`,`i_b1` in 1 each, top-half data
- `i_r2`,`i_g2`,`i_b2` in 1 each, bottom-half data
- `o_wr_valid` out 1, write request
- `i_wr_ready` in 1, write accept
- `o_wr_addr` out `addr_width_p`, pixel address = y*`hpixel_p` + x
- `o_wr_data` out [2:0][`bpp_p`-1:0], [2]=R, [1]=G, [0]=B
- `o_frame_done` out 1, one-cycle pulse after last write of row address 15
- `o_seq_err` out 1, one-cycle pulse on protocol error
- `o_overrun` out 1, one-cycle pulse when STB arrives during flush

## Operation
- Input conditioning: all 12 HUB75 inputs pass through identical sampling stages, then 1-cycle rising-edge detect on CLK and STB.
- Shift buffer: `hpixel_p` × 6 bits. On each CLK rise, shift in {R1,G1,B1,R2,G2,B2}. First bit after a latch ends at column `hpixel_p`-1; last bit lands in column 0. Shift counter 0..`hpixel_p`+1, saturating.
- On STB rise, sample A–D as `row`, then:
  - shift count ≠ `hpixel_p` -> pulse `o_seq_err`, discard latch; plane counter and buffer unchanged.
  - `row` ≠ `cur_row` and plane ≠ 0 -> pulse `o_seq_err`, restart at plane 0 for `row`.
  - Otherwise copy the shift buffer into bit `plane` of the accumulation buffer (`hpixel_p` × 6 × `bpp_p`); plane 0 = LSB. Set `cur_row` = `row` and clear the shift counter.
  - If plane = `bpp_p`-1, clear plane and enter FLUSH; else increment plane.
- States:
  - COLLECT: reset state. Goes to FLUSH on the final-plane latch.
  - FLUSH: issues 2*`hpixel_p` writes:
    - top half: x = 0..`hpixel_p`-1 at y = `cur_row`;
    - bottom half: same x at y = `cur_row`+16.
  - Returns to COLLECT after the last accepted write. Pulses `o_frame_done` with that return if `cur_row` = 15.
- Handshake: a write transfers when `o_wr_valid` && `i_wr_ready`. While stalled, `o_wr_addr` and `o_wr_data` are held stable. `o_wr_valid` never drops without a transfer, except on abort or reset.
- Overrun: STB rise in FLUSH pulses `o_overrun`, aborts the flush (`o_wr_valid` low next cycle) and processes the latch as above. CLK shifting continues during FLUSH.
- Reset: all outputs 0, state COLLECT, plane 0, `cur_row` 0, shift counter 0, buffers don't-care.

## Timing
- Pin edge to internal edge detect: 3 cycles with sync, 1 without.
- CLK rise and STB rise detected in the same cycle: the shift happens first and is included in the latch.
- Final-plane STB detect at cycle N -> `o_wr_valid` high at N+1. With `i_wr_ready` held high, one write per cycle, and the last write is at N+2*`hpixel_p`.
- `o_seq_err`, `o_overrun` assert the cycle after the STB detect.
- Reset asserted mid-flush clears `o_wr_valid` asynchronously. There is no partial-row resume.

## Configuration
- `HUB75_RX_SYNC_EN` defined: each input has a 2-flop synchronizer ahead of the edge-detect register.
- Undefined: inputs feed the edge-detect register directly. Use only when the source is driven from `clk` (same-clock loopback sim); latency drops by 2 cycles.

## Test plan
- Reset: `rst` high mid-flush -> `o_wr_valid`=0 immediately; all outputs 0; next full row decodes correctly.
- Single row: 8 latches on row 3, shifting R1=1 only in column 5 of plane 7 -> 128 writes; addr 197 data R=0x80 G=0 B=0; all others 0.
- Full frame of ramp pattern (pixel value = x ^ y) from `hub75_framebuf` in loopback -> capture matches 2048/2048 pixels; one `o_frame_done` after row 15.
- Backpressure: toggle `i_wr_ready` randomly 50% -> 128 writes, addresses contiguous; addr/data stable while stalled.
- Errors: 63 shifts then STB -> `o_seq_err` pulse, plane unchanged. Row change after plane 2 -> `o_seq_err`, new row decodes from plane 0.
- Overrun: STB during flush at write 40 -> `o_overrun`, `o_wr_valid` low next cycle, latch accepted as plane 0.
